phy_tx_lanes: RTL and testbench

PHY_TX_LANES -- requirements
Module: phy_tx_lanes

---
 rtl/phy_tx_lanes.sv | 149 ++++++++++++++
 tb/tb_phy_tx_lanes.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lanes.sv
// rtl/phy_tx_lanes.sv - word buffer and multi-lane byte serializer with startup idle sync
module phy_tx_lanes #(
  parameter int          DATA_W     = 32,
  parameter int          LANES      = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          SYNC_WORDS = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [LANES-1:0]  data_out,
  output logic              active_out,
  output logic              sync_done,
  output logic              overflow
);

  localparam int W   = DATA_W / LANES;
  localparam int BPL = W / 8;
  localparam int CW  = $clog2(W);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SCW = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_e;

  state_e                  state_q, state_d;
  logic                    run_q, run_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]          sync_cnt_q, sync_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];
  logic [LANES-1:0][W-1:0] shift_q, shift_d;
  logic [LANES-1:0][W-1:0] load_pattern;
  logic [LANES-1:0]        dout_q, dout_d;
  logic                    active_q, active_d;
  logic                    ovf_q, ovf_d;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    load_data;
  logic                    boundary;
  logic [DATA_W-1:0]       load_word;

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (state_q == ST_ACTIVE) && !fifo_full;
  assign sync_done  = (state_q == ST_ACTIVE);
  assign push       = valid_in && in_ready;
  // The first edge after reset starts a word so SYNC begins immediately.
  assign boundary   = !run_q || (bit_cnt_q == CW'(W - 1));
  // Occupancy is pre-edge, so a word written on this edge cannot be loaded on it.
  assign load_data  = boundary && (state_q == ST_ACTIVE) && !fifo_empty;
  assign load_word  = load_data ? mem_q[rd_ptr_q] : {(DATA_W/8){IDLE_BYTE}};

  assign data_out   = dout_q;
  assign active_out = active_q;
  assign overflow   = ovf_q;

  // Distribute bytes round-robin across lanes, each lane's bytes in word order.
  always_comb begin
    load_pattern = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < BPL; j++) begin
        load_pattern[l][W-1-8*j -: 8] = load_word[DATA_W-1-8*(l+j*LANES) -: 8];
      end
    end
  end

  // SYNC counts idle words, then hands over to ACTIVE for good.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (boundary && (state_q == ST_SYNC)) begin
      if (sync_cnt_q == SCW'(SYNC_WORDS)) begin
        state_d = ST_ACTIVE;
      end else begin
        sync_cnt_d = sync_cnt_q + SCW'(1);
      end
    end
  end

  // Bit counter, serializer, buffer pointers and sticky overflow.
  always_comb begin
    run_d     = 1'b1;
    bit_cnt_d = boundary ? '0 : bit_cnt_q + CW'(1);
    active_d  = boundary ? load_data : active_q;
    dout_d    = '0;
    shift_d   = shift_q;
    for (int l = 0; l < LANES; l++) begin
      if (boundary) begin
        dout_d[l]  = load_pattern[l][W-1];
        shift_d[l] = {load_pattern[l][W-2:0], 1'b0};
      end else begin
        dout_d[l]  = shift_q[l][W-1];
        shift_d[l] = {shift_q[l][W-2:0], 1'b0};
      end
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = load_data ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, load_data})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || ((state_q == ST_ACTIVE) && valid_in && fifo_full);
  end

  // State register; reset aborts any word in flight and flushes the buffer.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      run_q      <= 1'b0;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      active_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      active_q   <= active_d;
      ovf_q      <= ovf_d;
    end
  end

  // Buffer storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// tb/tb_phy_tx_lanes.sv - randomized bench with per-cycle reference model for two lane counts
module tb_phy_tx_lanes;

  localparam int DEPTH = 4;
  localparam int SW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;

  wire  [1:0]  dout_a;
  wire  [3:0]  dout_b;
  wire  [1:0]  act_v, rdy_v, sd_v, ovf_v;
  wire  [3:0]  dout_v [2];

  int checks = 0;
  int errors = 0;
  int ec = 0;

  assign dout_v[0] = {2'b00, dout_a};
  assign dout_v[1] = dout_b;

  always #5 clk = ~clk;

  phy_tx_lanes #(.DATA_W(32), .LANES(2), .FIFO_DEPTH(DEPTH), .SYNC_WORDS(SW), .IDLE_BYTE(8'hBC)) u_dut2 (
    .clk_32f(clk), .reset(rst_n), .data_in(data_in), .valid_in(valid_in),
    .in_ready(rdy_v[0]), .data_out(dout_a), .active_out(act_v[0]),
    .sync_done(sd_v[0]), .overflow(ovf_v[0]));

  phy_tx_lanes #(.DATA_W(32), .LANES(4), .FIFO_DEPTH(DEPTH), .SYNC_WORDS(SW), .IDLE_BYTE(8'hBC)) u_dut4 (
    .clk_32f(clk), .reset(rst_n), .data_in(data_in), .valid_in(valid_in),
    .in_ready(rdy_v[1]), .data_out(dout_b), .active_out(act_v[1]),
    .sync_done(sd_v[1]), .overflow(ovf_v[1]));

  // Reference model: time since release decides the phase, a queue holds accepted words.
  for (genvar d = 0; d < 2; d++) begin : g_model
    localparam int LN = (d == 0) ? 2 : 4;
    localparam int W  = 32 / LN;
    int          n = 0;
    logic [31:0] q[$];
    logic [31:0] cur = '0;
    bit          cur_act = 1'b0;
    logic [3:0]  e_dout = '0;
    bit          e_act = 1'b0, e_rdy = 1'b0, e_sd = 1'b0, e_ovf = 1'b0;

    initial forever begin
      int  b, s;
      bit  push, act_pre;
      logic [7:0] by;
      logic [7:0] idle;
      idle = 8'hBC;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; q.delete(); cur_act = 1'b0;
        e_dout = '0; e_act = 1'b0; e_rdy = 1'b0; e_sd = 1'b0; e_ovf = 1'b0;
      end else begin
        act_pre = (n >= SW*W + 1);
        push = 1'b0;
        if (valid_in && act_pre) begin
          if (q.size() < DEPTH) push = 1'b1;
          else e_ovf = 1'b1;
        end
        n++;
        b = (n - 1) % W;
        if (b == 0) begin
          s = (n - 1) / W;
          if (s >= SW && q.size() > 0) begin
            cur = q.pop_front();
            cur_act = 1'b1;
          end else begin
            cur_act = 1'b0;
          end
        end
        if (push) q.push_back(data_in);
        e_dout = '0;
        for (int l = 0; l < LN; l++) begin
          by = cur_act ? cur[31-8*(l+(b/8)*LN) -: 8] : idle;
          e_dout[l] = by[7-(b%8)];
        end
        e_act = cur_act;
        e_sd  = (n >= SW*W + 1);
        e_rdy = e_sd && (q.size() < DEPTH);
      end
    end

    initial forever begin
      logic [7:0] got, exp;
      @(negedge clk);
      exp = {e_dout, e_act, e_rdy, e_sd, e_ovf};
      got = {dout_v[d], act_v[d], rdy_v[d], sd_v[d], ovf_v[d]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_cmp_lanes%0d t=%0t: got %b expected %b (dout,act,rdy,sync,ovf)", LN, $time, got, exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rst_n) ec++;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_active(input int d);
    int bound = 0;
    while (act_v[d] !== 1'b1 && bound < 200) begin
      step();
      bound++;
    end
    if (bound >= 200) chk("wait_active_timeout", 64'(bound), 64'(0));
  endtask

  task automatic capture_a(output logic [15:0] l0, output logic [15:0] l1, output int nact);
    l0 = '0; l1 = '0; nact = 0;
    wait_active(0);
    for (int j = 0; j < 16; j++) begin
      l0 = {l0[14:0], dout_a[0]};
      l1 = {l1[14:0], dout_a[1]};
      nact += int'(act_v[0]);
      step();
    end
  endtask

  task automatic capture_b(output logic [31:0] w, output int nact);
    logic [7:0] ln [4];
    for (int l = 0; l < 4; l++) ln[l] = '0;
    nact = 0;
    wait_active(1);
    for (int j = 0; j < 8; j++) begin
      for (int l = 0; l < 4; l++) ln[l] = {ln[l][6:0], dout_b[l]};
      nact += int'(act_v[1]);
      step();
    end
    w = {ln[0], ln[1], ln[2], ln[3]};
  endtask

  // Release is done by the caller; walks the 64-clock SYNC phase of the 2-lane instance.
  task automatic sync_check();
    logic [15:0] l0, l1;
    int nact = 0;
    l0 = '0; l1 = '0;
    for (int i = 1; i <= 100; i++) begin
      if (i >= 20 && i < 30) begin
        valid_in = 1'b1;
        data_in = $urandom;
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (i <= 16) begin
        l0 = {l0[14:0], dout_a[0]};
        l1 = {l1[14:0], dout_a[1]};
      end
      nact += int'(act_v[0]);
      if (i == 64) chk("sync_not_ready_64", {rdy_v[0], sd_v[0], ovf_v[0]}, 3'b000);
      if (i == 65) chk("sync_ready_65", {rdy_v[0], sd_v[0]}, 2'b11);
    end
    chk("sync_lane0_idle", l0, 16'hBCBC);
    chk("sync_lane1_idle", l1, 16'hBCBC);
    chk("sync_no_active", 64'(nact), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l0, l1;
    logic [31:0] w;
    logic [31:0] bw [6];
    int nact;

    repeat (3) step();
    chk("reset_state", {dout_a, dout_b, act_v, rdy_v, sd_v, ovf_v}, 14'h0);

    // Startup
    rst_n = 1'b1; ec = 0;
    sync_check();

    // Single word on the 2-lane instance
    data_in = 32'hA1B2C3D4; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    capture_a(l0, l1, nact);
    chk("single_lane0", l0, 16'hA1C3);
    chk("single_lane1", l1, 16'hB2D4);
    chk("single_active_len", 64'(nact), 64'(16));
    chk("single_then_idle_act", act_v[0], 1'b0);
    l0 = '0;
    for (int j = 0; j < 8; j++) begin
      l0 = {l0[14:0], dout_a[0]};
      step();
    end
    chk("single_then_idle_byte", l0[7:0], 8'hBC);
    repeat (40) step();

    // Four lanes
    data_in = 32'h11223344; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    capture_b(w, nact);
    chk("lanes4_bytes", w, 32'h11223344);
    chk("lanes4_active_len", 64'(nact), 64'(8));
    repeat (40) step();

    // Full buffer with a push on the popping boundary edge
    while (ec % 16 != 1) step();
    for (int i = 0; i < 4; i++) begin
      data_in = $urandom; valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    while (ec % 16 != 0) step();
    chk("full_not_ready", rdy_v[0], 1'b0);
    chk("full_no_ovf_yet", ovf_v[0], 1'b0);
    data_in = $urandom; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("full_pop_ovf", ovf_v[0], 1'b1);
    chk("full_pop_ready", rdy_v[0], 1'b1);

    // Reset at bit 5 of the data word now in flight
    repeat (5) step();
    chk("midword_active", act_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midword_reset_zero", {dout_a, dout_b, act_v, rdy_v, sd_v, ovf_v}, 14'h0);
    repeat (3) step();
    rst_n = 1'b1; ec = 0;
    sync_check();

    // Burst of six starting at a word boundary
    while (ec % 16 != 0) step();
    for (int i = 0; i < 6; i++) begin
      bw[i] = $urandom;
      data_in = bw[i]; valid_in = 1'b1;
      step();
      if (i == 2) chk("burst_ready_3", rdy_v[0], 1'b1);
      if (i == 3) chk("burst_full_4", {rdy_v[0], ovf_v[0]}, 2'b00);
      if (i == 4) chk("burst_ovf_set", ovf_v[0], 1'b1);
    end
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      capture_a(l0, l1, nact);
      w = {l0[15:8], l1[15:8], l0[7:0], l1[7:0]};
      chk($sformatf("burst_word%0d", k), w, bw[k]);
    end
    chk("burst_then_idle", act_v[0], 1'b0);
    chk("burst_ovf_sticky", ovf_v[0], 1'b1);

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        valid_in = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      valid_in = (i < 1500) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
      data_in = $urandom;
      step();
    end
    valid_in = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
